// File: rtl/nobl_arb_pkg.sv
// nobl_arb_pkg : shared types for the NoBL command-port arbiter (rev 1.0)
`default_nettype none

package nobl_arb_pkg;

  typedef enum logic [0:0] {
    S_WR = 1'b0,
    S_RD = 1'b1
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/nobl_arb_credit.sv
// nobl_arb_credit : outstanding-read counter with sticky underflow flag (rev 1.0)
`default_nettype none

module nobl_arb_credit #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          underflow_o
);

  logic [CW-1:0] count_q, count_d;
  logic          uf_q, uf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      uf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      uf_q    <= uf_d;
    end
  end

  // A return with nothing in flight is flagged, and the count never wraps below zero.
  always_comb begin
    count_d = count_q;
    uf_d    = uf_q;
    if (dec_i && (count_q == '0)) uf_d = 1'b1;
    if (inc_i && !dec_i) begin
      count_d = count_q + CW'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  assign count_o     = count_q;
  assign underflow_o = uf_q;

endmodule

`default_nettype wire

// File: rtl/nobl_arb.sv
// nobl_arb : arbitrates one writer and one reader onto the NoBL SRAM command port (rev 1.0)
`default_nettype none

module nobl_arb
  import nobl_arb_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int DEPTH      = 19,
  parameter int BURST_MAX  = 8,
  parameter int RD_CREDITS = 4,
  parameter int CW         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DEPTH-1:0] rd_addr,
  input  logic             rd_valid,
  output logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_data_valid,
  output logic [DEPTH-1:0] address,
  output logic [WIDTH-1:0] data_out,
  output logic             write,
  output logic             enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  output logic [CW-1:0]    rd_outstanding,
  output logic             underflow_err
);

  localparam int            BW        = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);
  localparam logic [CW-1:0] CRED_LIM  = CW'(RD_CREDITS);

  owner_e        owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          grant, cur, oth;
  logic          ew, er;
  logic          wr_hs, rd_hs;

  logic             enable_q, write_q, rd_data_valid_q;
  logic [DEPTH-1:0] address_q;
  logic [WIDTH-1:0] data_out_q, rd_data_q;

  assign ew = wr_valid;
  assign er = rd_valid && (rd_outstanding < CRED_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= S_WR;
      burst_q <= '0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  // Whoever is granted always ends up as owner_d, so the readies derive from it.
  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    grant   = 1'b0;
    cur     = (owner_q == S_WR) ? ew : er;
    oth     = (owner_q == S_WR) ? er : ew;
    if (cur && (!oth || (burst_q < BURST_LIM))) begin
      grant = 1'b1;
      if (burst_q != BURST_LIM) burst_d = burst_q + BW'(1);
    end else if (oth) begin
      grant   = 1'b1;
      owner_d = (owner_q == S_WR) ? S_RD : S_WR;
      burst_d = BW'(1);
    end
  end

  always_comb begin
    wr_ready = grant && (owner_d == S_WR);
    rd_ready = grant && (owner_d == S_RD);
  end

  assign wr_hs = wr_valid && wr_ready;
  assign rd_hs = rd_valid && rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q        <= 1'b0;
      write_q         <= 1'b0;
      address_q       <= '0;
      data_out_q      <= '0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      enable_q        <= wr_hs || rd_hs;
      rd_data_q       <= data_in;
      rd_data_valid_q <= data_in_valid;
      if (wr_hs) begin
        write_q    <= 1'b1;
        address_q  <= wr_addr;
        data_out_q <= wr_data;
      end else if (rd_hs) begin
        write_q   <= 1'b0;
        address_q <= rd_addr;
      end
    end
  end

  nobl_arb_credit #(
    .CW (CW)
  ) u_credit (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_i       (rd_hs),
    .dec_i       (data_in_valid),
    .count_o     (rd_outstanding),
    .underflow_o (underflow_err)
  );

  assign enable        = enable_q;
  assign write         = write_q;
  assign address       = address_q;
  assign data_out      = data_out_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_nobl_arb.sv
// tb_nobl_arb : self-checking bench for nobl_arb (rev 1.0)
`timescale 1ns/1ps
`default_nettype none

module tb_nobl_arb;

  localparam int WIDTH      = 18;
  localparam int DEPTH      = 19;
  localparam int BURST_MAX  = 8;
  localparam int RD_CREDITS = 4;
  localparam int CW         = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DEPTH-1:0] wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [DEPTH-1:0] rd_addr = '0;
  logic             rd_valid = 1'b0;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic             rd_data_valid;
  logic [DEPTH-1:0] address;
  logic [WIDTH-1:0] data_out;
  logic             write;
  logic             enable;
  logic [WIDTH-1:0] data_in = '0;
  logic             data_in_valid = 1'b0;
  logic [CW-1:0]    rd_outstanding;
  logic             underflow_err;

  always #5 clk = ~clk;

  nobl_arb #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX),
    .RD_CREDITS(RD_CREDITS), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .address(address), .data_out(data_out), .write(write), .enable(enable),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .rd_outstanding(rd_outstanding), .underflow_err(underflow_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: who owns the port, how long they have held it, reads in flight.
  int m_owner, m_burst, m_out;
  bit m_uf, m_en, m_wr, m_rdv;
  int m_addr, m_dout, m_rdd;
  bit g_w, g_r;
  bit sw, sr;
  int ret_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_burst = 0; m_out = 0; m_uf = 0;
    m_en = 0; m_wr = 0; m_addr = 0; m_dout = 0; m_rdd = 0; m_rdv = 0;
    ret_q.delete();
  endtask

  task automatic model_grant();
    bit ew, er, cur, oth;
    ew  = wr_valid;
    er  = rd_valid && (m_out < RD_CREDITS);
    cur = (m_owner == 1) ? er : ew;
    oth = (m_owner == 1) ? ew : er;
    g_w = 0; g_r = 0;
    if (cur && (!oth || m_burst < BURST_MAX)) begin
      if (m_owner == 1) g_r = 1; else g_w = 1;
      if (m_burst < BURST_MAX) m_burst++;
    end else if (oth) begin
      m_owner = 1 - m_owner;
      m_burst = 1;
      if (m_owner == 1) g_r = 1; else g_w = 1;
    end
  endtask

  task automatic model_edge();
    m_en = g_w | g_r;
    if (g_w) begin
      m_wr = 1; m_addr = int'(wr_addr); m_dout = int'(wr_data);
    end else if (g_r) begin
      m_wr = 0; m_addr = int'(rd_addr);
    end
    if (data_in_valid && m_out == 0) m_uf = 1;
    if (g_r && !data_in_valid) m_out++;
    else if (data_in_valid && !g_r && m_out > 0) m_out--;
    m_rdd = int'(data_in);
    m_rdv = data_in_valid;
  endtask

  // Memory responder: a read accepted in cycle c returns data in cycle c+lat, in order.
  task automatic set_return();
    if (ret_q.size() > 0 && ret_q[0] == cyc) begin
      void'(ret_q.pop_front());
      data_in_valid = 1'b1;
      data_in       = WIDTH'($urandom);
    end else begin
      data_in_valid = 1'b0;
      data_in       = '0;
    end
  endtask

  task automatic step(input int lat);
    int t;
    #1;
    model_grant();
    sw = wr_ready;
    sr = rd_ready;
    chk("wr_ready", wr_ready, g_w);
    chk("rd_ready", rd_ready, g_r);
    chk("ready_exclusive", wr_ready & rd_ready, 0);
    if (lat > 0 && rd_valid && rd_ready) begin
      t = cyc + lat;
      if (ret_q.size() > 0 && t <= ret_q[$]) t = ret_q[$] + 1;
      ret_q.push_back(t);
    end
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("enable", enable, m_en);
    chk("write", write, m_wr);
    chk("address", address, m_addr);
    chk("data_out", data_out, m_dout);
    chk("rd_data_valid", rd_data_valid, m_rdv);
    chk("rd_data", rd_data, m_rdd);
    chk("rd_outstanding", rd_outstanding, m_out);
    chk("underflow_err", underflow_err, m_uf);
  endtask

  task automatic do_reset();
    wr_valid = 0; rd_valid = 0; data_in_valid = 0; data_in = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    chk("rst_enable", enable, 0);
    chk("rst_write", write, 0);
    chk("rst_address", address, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_data_valid", rd_data_valid, 0);
    chk("rst_rd_outstanding", rd_outstanding, 0);
    chk("rst_underflow", underflow_err, 0);
  endtask

  typedef struct packed {
    logic             wv, rv, dv;
    logic [WIDTH-1:0] din;
    logic             ewr, err;
    logic [CW-1:0]    eout;
    logic             euf, erdv;
  } vec_t;

  vec_t  tbl[14];
  string gpat;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 18'h00000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 18'h00000, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 18'h00000, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 18'h00000, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 18'h00000, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 18'h15555, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 18'h00000, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 18'h00011, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 18'h00022, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 18'h2AAAA, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 18'h3FFFF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 18'h00001, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 18'h00005, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};

    // Writes only: one command per cycle, address follows the handshake by one edge.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1; wr_addr = DEPTH'(i); wr_data = WIDTH'($urandom); rd_valid = 0;
      step(0);
      chk("t1_wr_ready", sw, 1);
      chk("t1_enable", enable, 1);
      chk("t1_write", write, 1);
      chk("t1_address", address, i);
    end

    // Both requesters busy, returns 3 cycles after the read handshake.
    do_reset();
    gpat = "WWWWWWWWRRRRRRRRWWWWWWWW";
    for (int i = 0; i < 24; i++) begin
      set_return();
      wr_valid = 1; rd_valid = 1;
      wr_addr = DEPTH'($urandom); rd_addr = DEPTH'($urandom); wr_data = WIDTH'($urandom);
      step(3);
      chk("t2_grant", {30'b0, sw, sr}, (gpat[i] == "W") ? 32'd2 : 32'd1);
    end

    // Credit exhaustion, same-cycle issue/return, read return path, underflow.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      wr_valid = tbl[i].wv; rd_valid = tbl[i].rv; rd_addr = DEPTH'(i + 100);
      data_in_valid = tbl[i].dv; data_in = tbl[i].din;
      step(0);
      chk("tbl_wr_ready", sw, tbl[i].ewr);
      chk("tbl_rd_ready", sr, tbl[i].err);
      chk("tbl_outstanding", rd_outstanding, tbl[i].eout);
      chk("tbl_underflow", underflow_err, tbl[i].euf);
      chk("tbl_rd_data_valid", rd_data_valid, tbl[i].erdv);
      if (tbl[i].erdv) chk("tbl_rd_data", rd_data, tbl[i].din);
    end

    // Asynchronous reset in the middle of a read burst.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      set_return();
      wr_valid = 1; rd_valid = 1;
      wr_addr = DEPTH'($urandom); rd_addr = DEPTH'($urandom); wr_data = WIDTH'($urandom);
      step(3);
    end
    chk("t6_pre_enable", enable, 1);
    chk("t6_pre_outstanding_nz", (rd_outstanding != 0) ? 1 : 0, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t6_async_enable", enable, 0);
    chk("t6_async_rd_data_valid", rd_data_valid, 0);
    chk("t6_async_outstanding", rd_outstanding, 0);
    data_in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    wr_valid = 1; rd_valid = 1;
    step(3);
    chk("t6_first_grant_writer", sw, 1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      set_return();
      wr_valid = ($urandom_range(0, 3) != 0);
      rd_valid = ($urandom_range(0, 3) != 0);
      wr_addr  = DEPTH'($urandom);
      rd_addr  = DEPTH'($urandom);
      wr_data  = WIDTH'($urandom);
      step($urandom_range(2, 5));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
